// File: rtl/vend_fsm.sv
// vend_fsm: coin-operated vending controller with registered outputs.
// Ports:
//   sys_clk, sys_rst_n        clock, synchronous active-low reset
//   coin_vld, coin_val        coin presented this cycle and its value
//   coin_rdy                  high in IDLE/COLLECT, when a coin can be taken
//   cancel                    refund request (only with VEND_REFUND_EN)
//   coke                      one-cycle dispense pulse
//   change_vld, change_val    change or refund amount, zero when not valid
//   credit                    accumulated credit
//   sold_cnt                  items dispensed, wrapping
// Option: define VEND_REFUND_EN to add the REFUND state and cancel handling.
module vend_fsm #(
    parameter int PRICE    = 3,
    parameter int COIN_W   = 2,
    parameter int CREDIT_W = 4,
    parameter int CNT_W    = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                coin_vld,
    input  logic [COIN_W-1:0]   coin_val,
    output logic                coin_rdy,
    input  logic                cancel,
    output logic                coke,
    output logic                change_vld,
    output logic [CREDIT_W-1:0] change_val,
    output logic [CREDIT_W-1:0] credit,
    output logic [CNT_W-1:0]    sold_cnt
);
`ifdef VEND_REFUND_EN
    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, REFUND} state_t;
`else
    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE} state_t;
`endif
    state_t              state_q;
    logic                coin_rdy_q, coke_q, chg_vld_q;
    logic [CREDIT_W-1:0] credit_q, chg_val_q;
    logic [CNT_W-1:0]    sold_q;
    logic                accept_d;
    logic [CREDIT_W:0]   sum_d;
    logic [CREDIT_W-1:0] chg_d;
`ifdef VEND_REFUND_EN
    logic [CREDIT_W-1:0] refund_d;
`else
    logic                unused_cancel;
    assign unused_cancel = cancel;
`endif

    // Sum is one bit wider than credit so the price compare cannot wrap.
    always_comb begin
        accept_d = coin_vld && coin_rdy_q && (coin_val != '0);
        sum_d    = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
        chg_d    = CREDIT_W'(sum_d - (CREDIT_W+1)'(PRICE));
`ifdef VEND_REFUND_EN
        refund_d = accept_d ? sum_d[CREDIT_W-1:0] : credit_q;
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            coke_q     <= 1'b0;
            chg_vld_q  <= 1'b0;
            chg_val_q  <= '0;
            sold_q     <= '0;
            coin_rdy_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE, COLLECT: begin
                    // A completing coin wins over a simultaneous cancel.
                    if (accept_d && sum_d >= (CREDIT_W+1)'(PRICE)) begin
                        state_q    <= DISPENSE;
                        coke_q     <= 1'b1;
                        chg_vld_q  <= chg_d != '0;
                        chg_val_q  <= chg_d;
                        coin_rdy_q <= 1'b0;
                    end
`ifdef VEND_REFUND_EN
                    else if (cancel && state_q == COLLECT) begin
                        state_q    <= REFUND;
                        credit_q   <= refund_d;
                        chg_vld_q  <= 1'b1;
                        chg_val_q  <= refund_d;
                        coin_rdy_q <= 1'b0;
                    end
`endif
                    else if (accept_d) begin
                        state_q  <= COLLECT;
                        credit_q <= sum_d[CREDIT_W-1:0];
                    end
                end
                DISPENSE: begin
                    state_q    <= IDLE;
                    credit_q   <= '0;
                    sold_q     <= sold_q + 1'b1;
                    coke_q     <= 1'b0;
                    chg_vld_q  <= 1'b0;
                    chg_val_q  <= '0;
                    coin_rdy_q <= 1'b1;
                end
`ifdef VEND_REFUND_EN
                REFUND: begin
                    state_q    <= IDLE;
                    credit_q   <= '0;
                    chg_vld_q  <= 1'b0;
                    chg_val_q  <= '0;
                    coin_rdy_q <= 1'b1;
                end
`endif
                default: begin
                    state_q    <= IDLE;
                    coin_rdy_q <= 1'b1;
                end
            endcase
        end
    end

    assign coin_rdy   = coin_rdy_q;
    assign coke       = coke_q;
    assign change_vld = chg_vld_q;
    assign change_val = chg_val_q;
    assign credit     = credit_q;
    assign sold_cnt   = sold_q;
endmodule
